sum_accumulator: RTL and testbench
==================================

Name: sum_accumulator

Overview:
- Downstream stage of the combinational operand adder.
- Consumes its DATA_WD+1-bit sum over a valid/ready handshake and accumulates ACC_CNT consecutive accepted sums into one wide result.
- Presents each result on a registered valid/ready output to the next consumer, e.g. the sim monitor or the next datapath stage.
- Accumulator width is chosen so the result never overflows.

Parameters:
DATA_WD, 16, operand width of the upstream adder; input sum is DATA_WD+1 bits
ACC_CNT, 4, accepted sums per result; legal range >=1
(derived, not overridable) CNT_WD = max(1, $clog2(ACC_CNT)); ACC_WD = DATA_WD+1+$clog2(ACC_CNT); defaults give 19

Ports:
i_clk  input  1  clock, all state updates on rising edge
i_rst  input  1  synchronous, active-high reset
i_sum  input  DATA_WD+1  sum from upstream adder, unsigned
i_valid  input  1  i_sum valid this cycle
o_ready  output  1  block accepts i_sum this cycle
o_acc  output  ACC_WD  accumulated result, registered
o_valid  output  1  o_acc valid, registered
i_ready  input  1  downstream accepts o_acc this cycle

Behaviour:
- Interface: one clock (i_clk); reset i_rst is synchronous and active-high.
- Reset, sampled at a rising edge with i_rst=1:
  - o_acc=0, o_valid=0, internal acc=0, cnt=0, state=ACCUM.
  - o_ready is 0 whenever i_rst=1 (combinational gate).
  - o_ready is 1 the first cycle after deassertion.
- Reset mid-operation discards any partial sum and any held result; no output is produced for that group.
- States:
  - ACCUM: o_ready=1.
  - HOLD: o_ready=0; o_valid=1.
- Input accept is i_valid && o_ready. i_sum is ignored otherwise, including in HOLD; upstream must hold it.
- ACCUM accept with cnt < ACC_CNT-1: acc <= acc + zero-extended i_sum; cnt <= cnt+1.
- ACCUM accept with cnt == ACC_CNT-1:
  - o_acc <= acc + i_sum, o_valid <= 1, acc <= 0, cnt <= 0, state -> HOLD.
  - Latency: o_valid is high the cycle after the final accept.
- ACC_CNT=1: every accept goes straight to HOLD.
- HOLD:
  - o_acc and o_valid are held stable while i_ready=0, for unbounded cycles.
  - On o_valid && i_ready: o_valid <= 0, state -> ACCUM. o_ready=1 on the following cycle.
- Throughput is at most one result per ACC_CNT+1 cycles; no overlap of HOLD with new accumulation.
- Arithmetic is unsigned and never overflows, since ACC_CNT*(2^(DATA_WD+1)-1) fits in ACC_WD bits. There is no wrap and no saturation.
- i_valid gaps in ACCUM leave acc and cnt unchanged.
- o_acc keeps its last value after the handshake; it is only meaningful when o_valid=1.

Optional Feature:
- Macro: SUM_ACC_CLR_EN.
- When defined, the block adds port i_clr (input, 1 bit): synchronous clear of the partial accumulation.
  - In ACCUM with i_clr=1: acc <= 0, cnt <= 0. o_ready is forced to 0 that cycle, so a simultaneous i_valid is not accepted.
  - In HOLD, i_clr is ignored; the pending result completes normally.
  - i_rst has priority over i_clr.
- When undefined, the i_clr port does not exist and behaviour is exactly as above.

Test Plan:
All scenarios use DATA_WD=16, ACC_CNT=4, ACC_WD=19.
1. Reset: assert i_rst 3 cycles with i_valid=1 -> o_valid=0, o_acc=0, o_ready=0 during reset; o_ready=1 the cycle after release.
2. Back-to-back: i_sum 1,2,3,4 on consecutive cycles, i_ready=1 -> o_valid=1, o_acc=10 exactly one cycle after the 4th accept. o_ready=0 that cycle, then 1 again; the next group starts from 0.
3. Max values: four accepts of i_sum=0x1FFFE -> o_acc=0x7FFF8, no overflow.
4. Backpressure: complete a group of 5,5,5,5 with i_ready=0 for 6 cycles while i_valid=1, i_sum=9 -> o_acc=20 stable, o_valid=1, o_ready=0, no 9 absorbed. Then i_ready=1 -> o_valid drops next cycle; the following group accumulates from 0.
5. Gapped input: i_valid pattern 1,0,0,1,0,1,1 with sums 5,x,x,7,x,9,11 -> o_acc=32, o_valid one cycle after the last accept.
6. Reset mid-group: accept 100,200, assert i_rst 1 cycle, then accept 1,1,1,1 -> o_acc=4. With SUM_ACC_CLR_EN: accept 100,200, pulse i_clr with i_valid=1/i_sum=50 (not accepted), then 1,1,1,1 -> o_acc=4.

Source files
------------

// File: rtl/sum_accumulator.sv
// Accumulates ACC_CNT accepted upstream sums into one registered result.
// Optional synchronous partial-sum clear port i_clr when SUM_ACC_CLR_EN is defined.
module sum_accumulator #(
    parameter int DATA_WD = 16,
    parameter int ACC_CNT = 4,
    localparam int CNT_WD = (ACC_CNT > 1) ? $clog2(ACC_CNT) : 1,
    localparam int ACC_WD = DATA_WD + 1 + $clog2(ACC_CNT)
) (
    input  logic              i_clk,
    input  logic              i_rst,
`ifdef SUM_ACC_CLR_EN
    input  logic              i_clr,
`endif
    input  logic [DATA_WD:0]  i_sum,
    input  logic              i_valid,
    output logic              o_ready,
    output logic [ACC_WD-1:0] o_acc,
    output logic              o_valid,
    input  logic              i_ready
);

    // Handshakes: a word transfers on a rising edge where valid && ready are both 1;
    // the sender holds data stable until then, and ready never waits on valid.
    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [CNT_WD-1:0] CNT_LAST = CNT_WD'(ACC_CNT - 1);

    state_t            state;
    state_t            state_nxt;
    logic [ACC_WD-1:0] acc;
    logic [CNT_WD-1:0] cnt;
    logic              clr;
    logic              accept;
    logic              last;

`ifdef SUM_ACC_CLR_EN
    assign clr = i_clr;
`else
    assign clr = 1'b0;
`endif

    assign accept = i_valid && o_ready;
    assign last   = (cnt == CNT_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= ACCUM;
            acc     <= '0;
            cnt     <= '0;
            o_acc   <= '0;
            o_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ACCUM) begin
                if (clr) begin
                    acc <= '0;
                    cnt <= '0;
                end else if (accept) begin
                    if (last) begin
                        o_acc   <= acc + ACC_WD'(i_sum);
                        o_valid <= 1'b1;
                        acc     <= '0;
                        cnt     <= '0;
                    end else begin
                        acc <= acc + ACC_WD'(i_sum);
                        cnt <= cnt + 1'b1;
                    end
                end
            end else if (i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM:   if (accept && last) state_nxt = HOLD;
            HOLD:    if (i_ready) state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    // Reset and clear gate ready combinationally so nothing is absorbed in those cycles.
    always_comb begin
        o_ready = 1'b0;
        if (!i_rst && !clr && state == ACCUM) o_ready = 1'b1;
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed plus random bench for sum_accumulator with a queue-based result scoreboard.
// Build with SUM_ACC_CLR_EN defined to also cover the partial-sum clear.
module tb_sum_accumulator;

    localparam int DATA_WD = 16;
    localparam int ACC_CNT = 4;
    localparam int ACC_WD  = 19;

    logic              i_clk = 1'b0;
    logic              i_rst;
`ifdef SUM_ACC_CLR_EN
    logic              i_clr;
`endif
    logic [DATA_WD:0]  i_sum;
    logic              i_valid;
    logic              o_ready;
    logic [ACC_WD-1:0] o_acc;
    logic              o_valid;
    logic              i_ready;

    logic [ACC_WD-1:0] exp_q[$];
    int                n_checks = 0;
    int                n_fail   = 0;

    logic [ACC_WD-1:0] m_acc;
    int                m_cnt;
    bit                m_hold;

    always #5 i_clk = ~i_clk;

    sum_accumulator #(.DATA_WD(DATA_WD), .ACC_CNT(ACC_CNT)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
`ifdef SUM_ACC_CLR_EN
        .i_clr   (i_clr),
`endif
        .i_sum   (i_sum),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_acc   (o_acc),
        .o_valid (o_valid),
        .i_ready (i_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // One cycle of stimulus; the model predicts ready/valid and queues finished groups.
    task automatic cyc(input logic v, input logic [DATA_WD:0] s, input logic r);
        i_valid = v;
        i_sum   = s;
        i_ready = r;
        #1;
        check("o_ready", 32'(o_ready), 32'(!m_hold));
        check("o_valid", 32'(o_valid), 32'(m_hold));
        if (m_hold) begin
            if (r) m_hold = 1'b0;
        end else if (v) begin
            m_acc = m_acc + ACC_WD'(s);
            m_cnt++;
            if (m_cnt == ACC_CNT) begin
                exp_q.push_back(m_acc);
                m_acc  = '0;
                m_cnt  = 0;
                m_hold = 1'b1;
            end
        end
        tick();
    endtask

    task automatic rst_cyc();
        i_rst   = 1'b1;
        i_valid = 1'b1;
        i_sum   = 17'd7;
        #1;
        check("rst_ready", 32'(o_ready), 32'd0);
        tick();
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_acc", 32'(o_acc), 32'd0);
        m_acc  = '0;
        m_cnt  = 0;
        m_hold = 1'b0;
        exp_q.delete();
    endtask

    // Scoreboard: each output handshake pops one expected result.
    always @(negedge i_clk) begin
        if (!i_rst && o_valid === 1'b1 && i_ready === 1'b1) begin
            if (exp_q.size() == 0) check("sb_underflow", 32'(exp_q.size()), 32'd1);
            else check("sb_acc", 32'(o_acc), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        i_rst   = 1'b1;
        i_valid = 1'b1;
        i_sum   = '0;
        i_ready = 1'b1;
`ifdef SUM_ACC_CLR_EN
        i_clr   = 1'b0;
`endif
        m_acc  = '0;
        m_cnt  = 0;
        m_hold = 1'b0;

        // Reset held three cycles with valid input present
        repeat (3) rst_cyc();
        i_rst = 1'b0;

        // Back-to-back group, one-cycle result latency
        cyc(1'b1, 17'd1, 1'b1);
        cyc(1'b1, 17'd2, 1'b1);
        cyc(1'b1, 17'd3, 1'b1);
        cyc(1'b1, 17'd4, 1'b1);
        check("b2b_acc", 32'(o_acc), 32'd10);
        cyc(1'b0, 17'd0, 1'b1);

        // Maximum sums without overflow
        repeat (4) cyc(1'b1, 17'h1FFFE, 1'b1);
        check("max_acc", 32'(o_acc), 32'h7FFF8);
        cyc(1'b0, 17'd0, 1'b1);

        // Backpressure: result held, pending input not absorbed
        repeat (4) cyc(1'b1, 17'd5, 1'b0);
        for (int i = 0; i < 6; i++) begin
            check("hold_acc", 32'(o_acc), 32'd20);
            cyc(1'b1, 17'd9, 1'b0);
        end
        cyc(1'b0, 17'd0, 1'b1);

        // Gapped input
        cyc(1'b1, 17'd5, 1'b1);
        cyc(1'b0, 17'($urandom_range(0, 1000)), 1'b1);
        cyc(1'b0, 17'($urandom_range(0, 1000)), 1'b1);
        cyc(1'b1, 17'd7, 1'b1);
        cyc(1'b0, 17'($urandom_range(0, 1000)), 1'b1);
        cyc(1'b1, 17'd9, 1'b1);
        cyc(1'b1, 17'd11, 1'b1);
        check("gap_acc", 32'(o_acc), 32'd32);
        cyc(1'b0, 17'd0, 1'b1);

        // Reset mid-group discards the partial sum
        cyc(1'b1, 17'd100, 1'b1);
        cyc(1'b1, 17'd200, 1'b1);
        rst_cyc();
        i_rst = 1'b0;
        repeat (4) cyc(1'b1, 17'd1, 1'b1);
        check("rstmid_acc", 32'(o_acc), 32'd4);
        cyc(1'b0, 17'd0, 1'b1);

`ifdef SUM_ACC_CLR_EN
        // Clear mid-group blocks the simultaneous input and drops the partial sum
        cyc(1'b1, 17'd100, 1'b1);
        cyc(1'b1, 17'd200, 1'b1);
        i_clr   = 1'b1;
        i_valid = 1'b1;
        i_sum   = 17'd50;
        #1;
        check("clr_ready", 32'(o_ready), 32'd0);
        tick();
        i_clr = 1'b0;
        m_acc = '0;
        m_cnt = 0;
        repeat (4) cyc(1'b1, 17'd1, 1'b1);
        check("clr_acc", 32'(o_acc), 32'd4);
        cyc(1'b0, 17'd0, 1'b1);
`endif

        // Random traffic with random backpressure
        repeat (60) cyc(1'($urandom_range(0, 1)), 17'($urandom_range(0, 17'h1FFFF)),
                        ($urandom_range(0, 3) != 0));
        repeat (3) cyc(1'b0, 17'd0, 1'b1);
        check("q_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
